// File: rtl/incubator_pkg.sv
// rtl/incubator_pkg.sv - shared types, widths and helpers for the incubator zone controller
package incubator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2
    } zone_state_e;

    localparam int RPS_W   = 4;
    localparam int RPS_MAX = 15;

    // Bits needed to hold a dwell count from 0 up to min_dwell.
    function automatic int dwell_w(input int min_dwell);
        return $clog2(min_dwell + 1);
    endfunction

endpackage

// File: rtl/incubator_zone_ctrl_if.sv
// rtl/incubator_zone_ctrl_if.sv - sample/actuator bundle between sensor logic, controller and drivers
interface incubator_zone_ctrl_if
    import incubator_pkg::*;
#(
    parameter int N_ZONES = 2,
    parameter int TW      = 8
);
    logic [N_ZONES*TW-1:0]    t;
    logic [N_ZONES-1:0]       zone_en;
    logic                     alarm_clr;
    logic [N_ZONES-1:0]       heater;
    logic [N_ZONES-1:0]       cooler;
    logic [N_ZONES*RPS_W-1:0] rps;
    logic [N_ZONES-1:0]       alarm;

    modport master (
        output t, zone_en, alarm_clr,
        input  heater, cooler, rps, alarm
    );

    modport slave (
        input  t, zone_en, alarm_clr,
        output heater, cooler, rps, alarm
    );
endinterface

// File: rtl/incubator_zone.sv
// rtl/incubator_zone.sv - one zone: hysteresis FSM, dwell timer, fan speed and optional alarm (INCUBATOR_ALARM_EN)
module incubator_zone
    import incubator_pkg::*;
#(
    parameter int TW           = 8,
    parameter int HEAT_ON      = 15,
    parameter int HEAT_OFF     = 25,
    parameter int COOL_ON      = 35,
    parameter int COOL_OFF     = 30,
    parameter int MIN_DWELL    = 4,
    parameter int RPS_SHIFT    = 2,
    parameter int ALARM_HI     = 50,
    parameter int ALARM_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [TW-1:0] t,
    input  logic                 en,
    input  logic                 alarm_clr,
    output logic                 heater,
    output logic                 cooler,
    output logic [RPS_W-1:0]     rps,
    output logic                 alarm
);
    localparam int DW = dwell_w(MIN_DWELL);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL - 1);

    localparam logic signed [TW-1:0] HEAT_ON_T  = TW'(HEAT_ON);
    localparam logic signed [TW-1:0] HEAT_OFF_T = TW'(HEAT_OFF);
    localparam logic signed [TW-1:0] COOL_ON_T  = TW'(COOL_ON);
    localparam logic signed [TW-1:0] COOL_OFF_T = TW'(COOL_OFF);

    // Fan datapath runs one bit wider than the sample so t - COOL_ON cannot wrap.
    localparam logic signed [TW:0] COOL_ON_X = (TW+1)'(COOL_ON);
    localparam logic signed [TW:0] RPS_MAX_X = (TW+1)'(RPS_MAX);
    localparam logic signed [TW:0] ONE_X     = (TW+1)'(1);

    zone_state_e       state_q, state_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [RPS_W-1:0]  rps_q, rps_d;
    logic [RPS_W-1:0]  rps_cool;
    logic signed [TW:0] t_ext, over, fan_step, fan_sum;

    // Fan speed the zone would run at if it is in COOL after this edge.
    always_comb begin
        t_ext    = {t[TW-1], t};
        over     = t_ext - COOL_ON_X;
        if (over < 0) begin
            over = '0;
        end
        fan_step = over >>> RPS_SHIFT;
        fan_sum  = fan_step + ONE_X;
        if (fan_sum > RPS_MAX_X) begin
            rps_cool = RPS_W'(RPS_MAX);
        end else begin
            rps_cool = fan_sum[RPS_W-1:0];
        end
    end

    // Next state, dwell countdown and registered fan speed.
    always_comb begin
        state_d = state_q;
        dwell_d = (dwell_q != '0) ? dwell_q - 1'b1 : dwell_q;
        if (!en) begin
            state_d = IDLE;
            dwell_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (t < HEAT_ON_T) begin
                        state_d = HEAT;
                        dwell_d = DWELL_LOAD;
                    end else if (t > COOL_ON_T) begin
                        state_d = COOL;
                        dwell_d = DWELL_LOAD;
                    end
                end
                HEAT: begin
                    if (t >= HEAT_OFF_T && dwell_q == '0) begin
                        state_d = IDLE;
                    end
                end
                COOL: begin
                    if (t <= COOL_OFF_T && dwell_q == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dwell_d = '0;
                end
            endcase
        end
        rps_d = (state_d == COOL) ? rps_cool : '0;
    end

    // Zone state, dwell timer and fan register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dwell_q <= '0;
            rps_q   <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            rps_q   <= rps_d;
        end
    end

    assign heater = (state_q == HEAT);
    assign cooler = (state_q == COOL);
    assign rps    = rps_q;

`ifdef INCUBATOR_ALARM_EN
    localparam int AW = $clog2(ALARM_CYCLES + 1);
    localparam logic [AW-1:0] RUN_MAX = AW'(ALARM_CYCLES);
    localparam logic signed [TW-1:0] ALARM_HI_T = TW'(ALARM_HI);

    logic [AW-1:0] run_q;
    logic [AW-1:0] run_inc;
    logic          alarm_q;

    // Saturating count of consecutive hot samples.
    always_comb begin
        run_inc = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
    end

    // Run counter and sticky alarm; clear dominates a same-edge raise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q   <= '0;
            alarm_q <= 1'b0;
        end else if (alarm_clr) begin
            run_q   <= '0;
            alarm_q <= 1'b0;
        end else if (t >= ALARM_HI_T) begin
            run_q <= run_inc;
            if (run_inc == RUN_MAX) begin
                alarm_q <= 1'b1;
            end
        end else begin
            run_q <= '0;
        end
    end

    assign alarm = alarm_q;
`else
    logic        unused_alarm_clr;
    logic [31:0] unused_alarm_cfg;

    assign unused_alarm_clr = alarm_clr;
    assign unused_alarm_cfg = ALARM_HI + ALARM_CYCLES;
    assign alarm            = 1'b0;
`endif

endmodule

// File: rtl/incubator_zone_ctrl.sv
// rtl/incubator_zone_ctrl.sv - multi-zone incubator controller top; alarm logic under INCUBATOR_ALARM_EN
module incubator_zone_ctrl
    import incubator_pkg::*;
#(
    parameter int N_ZONES      = 2,
    parameter int TW           = 8,
    parameter int HEAT_ON      = 15,
    parameter int HEAT_OFF     = 25,
    parameter int COOL_ON      = 35,
    parameter int COOL_OFF     = 30,
    parameter int MIN_DWELL    = 4,
    parameter int RPS_SHIFT    = 2,
    parameter int ALARM_HI     = 50,
    parameter int ALARM_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    incubator_zone_ctrl_if.slave bus
);

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
        incubator_zone #(
            .TW           (TW),
            .HEAT_ON      (HEAT_ON),
            .HEAT_OFF     (HEAT_OFF),
            .COOL_ON      (COOL_ON),
            .COOL_OFF     (COOL_OFF),
            .MIN_DWELL    (MIN_DWELL),
            .RPS_SHIFT    (RPS_SHIFT),
            .ALARM_HI     (ALARM_HI),
            .ALARM_CYCLES (ALARM_CYCLES)
        ) u_zone (
            .clk       (clk),
            .rst       (rst),
            .t         (bus.t[i*TW +: TW]),
            .en        (bus.zone_en[i]),
            .alarm_clr (bus.alarm_clr),
            .heater    (bus.heater[i]),
            .cooler    (bus.cooler[i]),
            .rps       (bus.rps[i*RPS_W +: RPS_W]),
            .alarm     (bus.alarm[i])
        );
    end

endmodule

// File: tb/tb_incubator_zone_ctrl.sv
// tb/tb_incubator_zone_ctrl.sv - self-checking bench for incubator_zone_ctrl
module tb_incubator_zone_ctrl;
    localparam int NZ = 2;
    localparam int TW = 8;

    localparam int S_IDLE = 0;
    localparam int S_HEAT = 1;
    localparam int S_COOL = 2;

`ifdef INCUBATOR_ALARM_EN
    localparam int ALARM_ON = 1;
`else
    localparam int ALARM_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    incubator_zone_ctrl_if #(.N_ZONES(NZ), .TW(TW)) bus ();

    incubator_zone_ctrl #(.N_ZONES(NZ), .TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state[NZ];
    int m_age[NZ];
    int m_run[NZ];
    int m_alarm[NZ];
    int m_rps[NZ];
    int cur_t[NZ];
    bit [NZ-1:0] cur_en;
    bit          cur_clr;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fan_speed(input int tv);
        int d;
        int v;
        d = tv - 35;
        if (d < 0) d = 0;
        v = 1 + d / 4;
        if (v > 15) v = 15;
        return v;
    endfunction

    task automatic model_reset();
        for (int z = 0; z < NZ; z++) begin
            m_state[z] = S_IDLE;
            m_age[z]   = 0;
            m_run[z]   = 0;
            m_alarm[z] = 0;
            m_rps[z]   = 0;
        end
    endtask

    task automatic model_edge();
        for (int z = 0; z < NZ; z++) begin
            int tv;
            tv = cur_t[z];
            if (ALARM_ON != 0) begin
                if (cur_clr) begin
                    m_run[z]   = 0;
                    m_alarm[z] = 0;
                end else if (tv >= 50) begin
                    if (m_run[z] < 3) m_run[z]++;
                    if (m_run[z] == 3) m_alarm[z] = 1;
                end else begin
                    m_run[z] = 0;
                end
            end
            if (!cur_en[z]) begin
                m_state[z] = S_IDLE;
                m_age[z]   = 0;
            end else if (m_state[z] == S_IDLE) begin
                if (tv < 15) begin
                    m_state[z] = S_HEAT;
                    m_age[z]   = 1;
                end else if (tv > 35) begin
                    m_state[z] = S_COOL;
                    m_age[z]   = 1;
                end
            end else if (m_state[z] == S_HEAT) begin
                if (tv >= 25 && m_age[z] >= 4) begin
                    m_state[z] = S_IDLE;
                    m_age[z]   = 0;
                end else if (m_age[z] < 1000) begin
                    m_age[z]++;
                end
            end else begin
                if (tv <= 30 && m_age[z] >= 4) begin
                    m_state[z] = S_IDLE;
                    m_age[z]   = 0;
                end else if (m_age[z] < 1000) begin
                    m_age[z]++;
                end
            end
            m_rps[z] = (m_state[z] == S_COOL) ? fan_speed(tv) : 0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int z = 0; z < NZ; z++) begin
            check($sformatf("%s.heater%0d", tag, z), int'(bus.heater[z]), int'(m_state[z] == S_HEAT));
            check($sformatf("%s.cooler%0d", tag, z), int'(bus.cooler[z]), int'(m_state[z] == S_COOL));
            check($sformatf("%s.rps%0d", tag, z), int'(bus.rps[z*4 +: 4]), m_rps[z]);
            check($sformatf("%s.alarm%0d", tag, z), int'(bus.alarm[z]), m_alarm[z]);
        end
    endtask

    task automatic drive(input int t0, input int t1, input bit [1:0] en, input bit clr);
        logic [7:0] b0;
        logic [7:0] b1;
        cur_t[0]      = t0;
        cur_t[1]      = t1;
        cur_en        = en;
        cur_clr       = clr;
        b0            = 8'(t0);
        b1            = 8'(t1);
        bus.t         = {b1, b0};
        bus.zone_en   = en;
        bus.alarm_clr = clr;
    endtask

    task automatic step(input string tag, input int t0, input int t1,
                        input bit [1:0] en, input bit clr);
        drive(t0, t1, en, clr);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0;
        drive(22, 22, 2'b11, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        step("idle", 22, 22, 2'b11, 1'b0);
        step("idle", 22, 22, 2'b11, 1'b0);
        check("idle_lit.heater0", int'(bus.heater[0]), 0);

        // heat hysteresis
        step("heat", -9, 10, 2'b11, 1'b0);
        check("heat_enter", int'(bus.heater[0]), 1);
        step("heat", 25, 10, 2'b11, 1'b0);
        check("heat_dwell_hold", int'(bus.heater[0]), 1);
        step("heat", 20, 10, 2'b11, 1'b0);
        step("heat", 25, 10, 2'b11, 1'b0);
        check("heat_dwell_hold2", int'(bus.heater[0]), 1);
        step("heat", 25, 10, 2'b11, 1'b0);
        check("heat_exit", int'(bus.heater[0]), 0);

        // cooling and fan curve
        step("cool", 36, 10, 2'b11, 1'b0);
        check("cool_enter", int'(bus.cooler[0]), 1);
        check("rps_36", int'(bus.rps[3:0]), 1);
        step("cool", 42, 10, 2'b11, 1'b0);
        check("rps_42", int'(bus.rps[3:0]), 2);
        step("cool", 55, 10, 2'b11, 1'b0);
        check("rps_55", int'(bus.rps[3:0]), 6);
        step("cool", 100, 10, 2'b11, 1'b0);
        check("rps_100_sat", int'(bus.rps[3:0]), 15);
        step("cool", 33, 10, 2'b11, 1'b0);
        check("rps_band", int'(bus.rps[3:0]), 1);
        step("cool", 30, 10, 2'b11, 1'b0);
        check("cool_exit", int'(bus.cooler[0]), 0);
        check("cool_exit_rps", int'(bus.rps[3:0]), 0);

        // crossover through IDLE, then enable drop
        step("cross", -9, 10, 2'b11, 1'b0);
        repeat (3) step("cross", 20, 10, 2'b11, 1'b0);
        step("cross", 40, 10, 2'b11, 1'b0);
        check("cross_idle_h", int'(bus.heater[0]), 0);
        check("cross_idle_c", int'(bus.cooler[0]), 0);
        step("cross", 40, 10, 2'b11, 1'b0);
        check("cross_cool", int'(bus.cooler[0]), 1);
        step("zen", 40, 10, 2'b10, 1'b0);
        check("zen_force_idle", int'(bus.cooler[0]), 0);
        check("zen_zone1_heat", int'(bus.heater[1]), 1);
        step("zen", 40, 10, 2'b11, 1'b0);

        // async reset between edges, mid-COOL
        step("areset", 40, 10, 2'b11, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("areset.cooler0", int'(bus.cooler[0]), 0);
        check("areset.rps0", int'(bus.rps[3:0]), 0);
        check("areset.heater1", int'(bus.heater[1]), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all("areset_hold");
        step("fresh", 36, 10, 2'b11, 1'b0);
        repeat (3) step("fresh", 30, 10, 2'b11, 1'b0);
        check("fresh_dwell_hold", int'(bus.cooler[0]), 1);
        step("fresh", 30, 10, 2'b11, 1'b0);
        check("fresh_exit", int'(bus.cooler[0]), 0);

        // over-temperature alarm
        step("alarm", 50, 22, 2'b11, 1'b0);
        step("alarm", 51, 22, 2'b11, 1'b0);
        step("alarm", 49, 22, 2'b11, 1'b0);
        step("alarm", 50, 22, 2'b11, 1'b0);
        step("alarm", 50, 22, 2'b11, 1'b0);
        check("alarm_not_yet", int'(bus.alarm[0]), 0);
        step("alarm", 50, 22, 2'b11, 1'b0);
        check("alarm_raise", int'(bus.alarm[0]), ALARM_ON);
        step("alarm", 20, 22, 2'b11, 1'b0);
        check("alarm_sticky", int'(bus.alarm[0]), ALARM_ON);
        step("alarm", 20, 22, 2'b11, 1'b1);
        check("alarm_clear", int'(bus.alarm[0]), 0);

        // clear wins over a same-edge raise
        step("clrwin", 60, 22, 2'b11, 1'b0);
        step("clrwin", 60, 22, 2'b11, 1'b0);
        step("clrwin", 60, 22, 2'b11, 1'b1);
        check("clr_wins", int'(bus.alarm[0]), 0);
        step("clrwin", 60, 22, 2'b11, 1'b0);
        step("clrwin", 60, 22, 2'b11, 1'b0);
        check("clr_rearm_wait", int'(bus.alarm[0]), 0);
        step("clrwin", 60, 22, 2'b11, 1'b0);
        check("clr_rearm", int'(bus.alarm[0]), ALARM_ON);

        // randomized phase against the model
        for (int n = 0; n < 600; n++) begin
            int tv[NZ];
            bit [1:0] en;
            bit clr;
            for (int z = 0; z < NZ; z++) begin
                if ($urandom_range(0, 3) == 0)
                    tv[z] = int'($urandom_range(0, 255)) - 128;
                else
                    tv[z] = int'($urandom_range(5, 60));
                en[z] = ($urandom_range(0, 15) != 0);
            end
            clr = ($urandom_range(0, 19) == 0);
            step("rnd", tv[0], tv[1], en, clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/incubator_zone_ctrl.md
Name: incubator_zone_ctrl

Overview:
Multi-zone successor to the single-channel incubator controller. Each of N_ZONES independent zones takes a signed temperature sample and drives its own heater, cooler and fan-speed (rps) outputs. Each zone runs a registered hysteresis FSM with a minimum-dwell timer and a per-zone enable. The block sits between the sensor-sampling logic and the actuator drivers.

Parameters:
N_ZONES, 2, number of independent zones
TW, 8, temperature width in bits, signed two's complement
HEAT_ON, 15, enter HEAT when t < HEAT_ON
HEAT_OFF, 25, leave HEAT when t >= HEAT_OFF
COOL_ON, 35, enter COOL when t > COOL_ON
COOL_OFF, 30, leave COOL when t <= COOL_OFF
MIN_DWELL, 4, minimum cycles spent in HEAT/COOL before exit (>=1)
RPS_SHIFT, 2, fan-speed slope: one rps step per 2^RPS_SHIFT degrees above COOL_ON
ALARM_HI, 50, over-temperature alarm threshold (optional feature only)
ALARM_CYCLES, 3, consecutive samples >= ALARM_HI needed to raise alarm (optional feature only)
Legal ordering: HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
t  in  N_ZONES*TW  signed temperature per zone; zone i at [i*TW +: TW]
zone_en  in  N_ZONES  per-zone enable
alarm_clr  in  1  clears all sticky alarms
heater  out  N_ZONES  heater on, per zone
cooler  out  N_ZONES  cooler on, per zone
rps  out  N_ZONES*4  fan speed per zone, 0..15
alarm  out  N_ZONES  sticky over-temperature alarm, per zone

Behaviour:
- Reset (rst=0, asynchronous): every zone goes to IDLE and its dwell counter clears. heater, cooler, rps and alarm are all 0.
- All outputs are registered. Latency is 1 cycle: the sample on edge k sets the outputs visible after edge k. t is sampled every cycle; no handshake.
- Per-zone FSM states: IDLE, HEAT, COOL (encoding lives in the package). heater = (state==HEAT); cooler = (state==COOL).
- IDLE -> HEAT when t < HEAT_ON. IDLE -> COOL when t > COOL_ON. Otherwise stay in IDLE.
- Entering HEAT or COOL loads the dwell counter with MIN_DWELL-1. The counter decrements each cycle while nonzero.
- HEAT -> IDLE when t >= HEAT_OFF and dwell == 0.
- COOL -> IDLE when t <= COOL_OFF and dwell == 0.
- No direct HEAT<->COOL transition. A jump across both bands goes through IDLE for exactly one cycle, then into the opposite state on the next cycle if the condition still holds.
- zone_en=0: the zone is forced to IDLE on the next edge regardless of dwell, and the counter clears. Its alarm logic keeps running.
- rps, computed at TW+1 bits signed:
  - In COOL: rps = min(15, 1 + (max(0, t-COOL_ON) >> RPS_SHIFT)).
  - In IDLE or HEAT: rps = 0.
  - The hysteresis band (COOL_OFF < t <= COOL_ON) while in COOL gives rps = 1.
- Signed comparisons throughout; negative t is valid (e.g. -9 gives HEAT).
- Zones are fully independent; simultaneous events in different zones do not interact.

Optional Feature:
Macro INCUBATOR_ALARM_EN.
- Defined: each zone has a saturating run counter.
  - It increments while t >= ALARM_HI and resets to 0 otherwise.
  - When it reaches ALARM_CYCLES, alarm[i] sets and stays set (sticky).
  - alarm_clr=1 clears all alarms and run counters on the next edge. If set and clear happen on the same edge, clear wins, and the alarm re-raises only after ALARM_CYCLES new qualifying samples.
- Not defined: the alarm port is present and tied to 0; no counter logic exists. ALARM_HI and ALARM_CYCLES are unused.

Decomposition:
Package incubator_pkg holds:
- the zone state enum (IDLE=2'd0, HEAT=2'd1, COOL=2'd2)
- RPS_W=4 and RPS_MAX=15
- the dwell counter width function $clog2(MIN_DWELL+1)

Sub-module incubator_zone contains one FSM, dwell counter, rps datapath and optional alarm. The top generates N_ZONES instances and slices the buses.

Test Plan:
Defaults, zone 0 unless noted.
- Reset/IDLE: rst=0 for 2 cycles with t=22 in both zones, then release -> heater=cooler=0, rps=0, alarm=0; stays IDLE at t=22.
- Heat hysteresis: t=-9 -> heater=1 after 1 edge; t=20 -> heater stays 1; t=25 at cycle >=4 after entry -> heater=0 next edge; t=25 at entry+1 -> heater held until dwell expires.
- Cool and fan: t=36 -> cooler=1, rps=1; t=42 -> rps=2; t=55 -> rps=6; t=100 -> rps=15 (saturated); t=33 -> cooler=1, rps=1; t=30 after dwell -> cooler=0, rps=0.
- Crossover and enable: in HEAT after dwell, t=40 -> IDLE for 1 cycle, then COOL. zone_en[0]=0 mid-COOL with dwell=3 -> IDLE next edge. Zone 1 at t=10 is unaffected throughout (heater[1]=1).
- Async reset mid-operation: rst asserted between edges while in COOL with dwell=2 -> outputs 0 immediately without waiting for a clock edge; after release at t=36 -> fresh entry with full MIN_DWELL.
- Alarm (INCUBATOR_ALARM_EN): t=50,51,49,50,50,50 -> alarm rises after the 6th sample and stays set at t=20; alarm_clr pulse -> 0. Without the macro, the same stimulus gives alarm=0.
